joy_serializer: RTL and testbench
=================================

# joy_serializer

Transmitter end of the two-player serial joystick link. It emulates the parallel-in/serial-out shift-register chain that the arcade top-level polls with JOY_CLK, JOY_LOAD and JOY_DATA. It snapshots two 12-bit active-low joystick words on JOY_LOAD and shifts them out MSB-first on JOY_CLK rising edges. Typical uses: the adapter-side FPGA or CPLD, and the loopback model in the core's simulation bench.

## Interface
Parameters:
- LEAD_BITS, default 1: number of constant-1 dummy slots sent before data slot 0 (range 0..4).

Ports:
- clk12 in 1: system clock, 12 MHz.
- reset in 1: asynchronous, active-high.
- joy1 in 12: player-1 buttons, active-low (1 = released).
- joy2 in 12: player-2 buttons, active-low.
- JOY_CLK in 1: serial shift clock from the poller. It is asynchronous to clk12.
- JOY_LOAD in 1: active-low parallel load from the poller. It is asynchronous to clk12.
- JOY_DATA out 1: serial data.
- frame_done out 1: one-cycle pulse when the last data slot has been shifted out.
- bit_cnt out 5: number of shifts since the last load. It saturates at LEAD_BITS+24.

## Operation
- **Synchronisers.** JOY_CLK and JOY_LOAD each pass through 2 flip-flops, plus a third flip-flop on JOY_CLK for edge detection.
  - JOY_CLK synchroniser reset value: 0.
  - JOY_LOAD synchroniser reset value: 1.
- **Shift register.** sr has width LEAD_BITS+24. JOY_DATA = sr[MSB], registered.
- **Load image**, MSB first:
  - LEAD_BITS ones;
  - joy1[8], joy1[6], joy1[5], joy1[4], joy1[3], joy1[2], joy1[1], joy1[0];
  - joy2[8], joy2[6], joy2[5], joy2[4], joy2[3], joy2[2], joy2[1], joy2[0];
  - joy2[10], joy2[11], joy2[9], joy2[7];
  - joy1[10], joy1[11], joy1[9], joy1[7].
- **Load.** While the synchronised JOY_LOAD is 0:
  - sr reloads every cycle, so it follows live inputs, as a 165-style chain does;
  - bit_cnt = 0;
  - JOY_CLK edges are ignored.
- **Shift.** A synchronised JOY_CLK rising edge while JOY_LOAD = 1 does the following:
  - sr <= {sr[MSB-1:0], 1'b1};
  - bit_cnt increments unless it is already at LEAD_BITS+24.
- **Frame end.**
  - frame_done asserts for exactly one cycle on the shift that takes bit_cnt from LEAD_BITS+23 to LEAD_BITS+24.
  - After that, JOY_DATA stays at 1 and further edges do not change bit_cnt or pulse frame_done.
- **Simultaneous events.** If a JOY_CLK rising edge and JOY_LOAD = 0 occur in the same cycle, the load wins and no shift or count occurs.
- **Reload mid-frame.** JOY_LOAD falling before the frame completes aborts the frame. sr reloads, bit_cnt returns to 0, and no frame_done pulse is produced.
- **Reset values.**
  - sr = all ones, so JOY_DATA = 1 (no buttons pressed).
  - bit_cnt = 0.
  - frame_done = 0.
  - Reset mid-frame takes effect immediately and the frame is abandoned.
- **Input sampling.** joy1 and joy2 are sampled only while loading; changes during shifting do not affect the frame in flight.

## Timing
- **Shift latency.** JOY_DATA updates 3 clk12 cycles after a JOY_CLK rising edge at the pin (2 synchroniser stages plus the sr register).
  - The poller samples JOY_DATA on the same rising edge, so it always sees the pre-shift value.
- **Load latency.** sr reflects the inputs 3 cycles after JOY_LOAD falls at the pin (2 synchroniser stages plus the sr register). JOY_DATA shows the first slot in that same cycle.
- **Minimum input pulse widths.** JOY_CLK high, JOY_CLK low and JOY_LOAD low must each last at least 3 clk12 cycles; shorter pulses may be missed. The nominal poller meets this: JOY_CLK has a 32-cycle period, and JOY_LOAD is low for one full JOY_CLK period.
- **frame_done** is coincident with the cycle in which JOY_DATA takes the first fill 1.

## Test plan
1. **Reset.** Assert reset with joy1 = 12'h000 and JOY_CLK toggling -> JOY_DATA = 1, bit_cnt = 0, frame_done = 0 throughout reset.
2. **Basic frame.** LEAD_BITS = 1, joy1 = 12'hFFE (bit0 pressed), joy2 = 12'hFFF; load then 26 JOY_CLK edges -> sampled stream is 1 (lead), then slot 8 (joy1[0]) = 0, all other slots 1. frame_done pulses once, after edge 25.
3. **Bit-order sweep.** Walking-zero across joy1 and joy2, all 24 bits -> each zero appears in exactly the slot listed in the load image order.
4. **Load/clock collision.** Assert JOY_LOAD low in the same synchronised cycle as a JOY_CLK edge -> no shift, bit_cnt = 0, JOY_DATA = first slot.
5. **Mid-frame reload.** Load, shift 10 edges, reload with new joy values -> bit_cnt = 0, new image is output, no frame_done pulse. Also assert reset at shift 5 -> JOY_DATA = 1 within the reset cycle.
6. **Saturation.** Load, then 40 edges -> bit_cnt holds 25, exactly one frame_done pulse, JOY_DATA = 1 after edge 25. Inputs changed during shifting are not reflected in the stream.

Source files
------------

// File: rtl/joy_serializer.sv
// ---------------------------------------------------------------------------
// joy_serializer
//
// Transmitter end of the two-player serial joystick link. Emulates a
// parallel-in/serial-out shift-register chain polled by JOY_CLK / JOY_LOAD.
// While JOY_LOAD is low the chain continuously reloads from the two
// active-low joystick words. On each JOY_CLK rising edge it shifts one slot
// out on JOY_DATA, MSB first, and fills with ones.
//
// Ports:
//   clk12      - 12 MHz system clock
//   reset      - asynchronous, active-high reset
//   joy1/joy2  - 12-bit active-low button words (1 = released)
//   JOY_CLK    - serial shift clock from the poller (asynchronous)
//   JOY_LOAD   - active-low parallel load from the poller (asynchronous)
//   JOY_DATA   - serial data out (MSB of the shift register)
//   frame_done - one-cycle pulse when the last data slot has been shifted out
//   bit_cnt    - shifts since the last load, saturating at LEAD_BITS+24
// ---------------------------------------------------------------------------
module joy_serializer #(
    parameter int LEAD_BITS = 1
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic [11:0] joy1,
    input  logic [11:0] joy2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic [4:0]  bit_cnt
);

    localparam int         SR_W    = LEAD_BITS + 24;
    localparam logic [4:0] CNT_MAX = 5'(SR_W);

    // Synchroniser chains; the extra JOY_CLK stage provides edge detection.
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic load_meta_q, load_sync_q;

    logic [SR_W-1:0] sr_q, sr_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic            frame_done_q, frame_done_d;

    logic            clk_rise;
    logic [SR_W-1:0] load_image;

    // JOY_CLK idles low and JOY_LOAD idles high (not loading) out of reset,
    // so release from reset never produces a spurious shift or load.
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            clk_meta_q  <= 1'b0;
            clk_sync_q  <= 1'b0;
            clk_prev_q  <= 1'b0;
            load_meta_q <= 1'b1;
            load_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= JOY_CLK;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            load_meta_q <= JOY_LOAD;
            load_sync_q <= load_meta_q;
        end
    end

    assign clk_rise = clk_sync_q & ~clk_prev_q;

    // Lead slots are constant ones; the data slots follow the poller's
    // expected button order. Filling with '1 first covers the lead slots
    // for any LEAD_BITS, including zero.
    always_comb begin
        load_image       = '1;
        load_image[23:0] = {joy1[8], joy1[6], joy1[5:0],
                            joy2[8], joy2[6], joy2[5:0],
                            joy2[10], joy2[11], joy2[9], joy2[7],
                            joy1[10], joy1[11], joy1[9], joy1[7]};
    end

    // Load has priority over a coincident shift. Once the count saturates,
    // further shifts only push in more fill ones and never re-pulse
    // frame_done.
    always_comb begin
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        if (!load_sync_q) begin
            sr_d      = load_image;
            bit_cnt_d = 5'd0;
        end else if (clk_rise) begin
            sr_d = {sr_q[SR_W-2:0], 1'b1};
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d    = bit_cnt_q + 5'd1;
                frame_done_d = (bit_cnt_q == CNT_MAX - 5'd1);
            end
        end
    end

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            sr_q         <= '1;
            bit_cnt_q    <= 5'd0;
            frame_done_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign JOY_DATA   = sr_q[SR_W-1];
    assign frame_done = frame_done_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_joy_serializer.sv
// ---------------------------------------------------------------------------
// tb_joy_serializer
//
// Self-checking bench for joy_serializer (LEAD_BITS = 1). A behavioural
// model tracks the serial stream as "slot k of the snapshot image", where k
// is the number of JOY_CLK edges since the last load. It predicts JOY_DATA,
// bit_cnt and frame_done once the pin events have propagated through the
// synchronisers and the shift register.
// ---------------------------------------------------------------------------
module tb_joy_serializer;

    localparam int LEAD = 1;
    localparam int W    = LEAD + 24;

    logic        clk12 = 1'b0;
    logic        reset;
    logic [11:0] joy1, joy2;
    logic        JOY_CLK, JOY_LOAD;
    logic        JOY_DATA, frame_done;
    logic [4:0]  bit_cnt;

    always #5 clk12 = ~clk12;

    joy_serializer #(.LEAD_BITS(LEAD)) dut (
        .clk12      (clk12),
        .reset      (reset),
        .joy1       (joy1),
        .joy2       (joy2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Source bit of each data slot within {joy2, joy1}; joy2 bit b is 12+b.
    const int slot_src [24] = '{8, 6, 5, 4, 3, 2, 1, 0,
                                20, 18, 17, 16, 15, 14, 13, 12,
                                22, 23, 21, 19,
                                10, 11, 9, 7};

    // Model state
    logic [23:0] m_word;
    int          m_cnt;
    bit          m_loading;
    bit          m_fd_pending;
    int          settled;
    int          fd_count = 0;

    logic [23:0] cmp_word;
    int          cmp_k;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input int k, input logic [23:0] w);
        if (k < LEAD) return 1'b1;
        if (k < W)    return w[slot_src[k-LEAD]];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_word       = '1;
        m_cnt        = 0;
        m_loading    = 0;
        m_fd_pending = 0;
        settled      = 100;
    endtask

    // Number of clk12 rising edges since the last output-affecting pin event.
    always @(posedge clk12) if (settled < 1000) settled++;

    // Per-cycle comparison once the latest pin event has propagated
    // (two synchroniser stages plus the shift register).
    always @(negedge clk12) begin
        if (frame_done === 1'b1) fd_count++;
        if (reset) begin
            checkOutput("rst_data", 32'(JOY_DATA), 32'd1);
            checkOutput("rst_cnt", 32'(bit_cnt), 32'd0);
            checkOutput("rst_fd", 32'(frame_done), 32'd0);
        end else if (settled >= 3) begin
            cmp_word = m_loading ? {joy2, joy1} : m_word;
            cmp_k    = m_loading ? 0 : m_cnt;
            checkOutput("data", 32'(JOY_DATA), 32'(exp_bit(cmp_k, cmp_word)));
            checkOutput("cnt", 32'(bit_cnt), 32'(cmp_k));
            checkOutput("fd", 32'(frame_done),
                        32'(m_fd_pending && settled == 3));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk12);
    endtask

    task automatic set_joy(input logic [11:0] j1, input logic [11:0] j2);
        @(negedge clk12); #1;
        joy1 = j1;
        joy2 = j2;
        if (!reset && m_loading) settled = 0;
    endtask

    task automatic set_load(input logic v);
        @(negedge clk12); #1;
        JOY_LOAD = v;
        if (!reset) begin
            if (!v) begin
                m_loading    = 1;
                m_cnt        = 0;
                m_fd_pending = 0;
            end else begin
                m_loading = 0;
                m_word    = {joy2, joy1};
            end
            settled = 0;
        end
        wait_cycles(4);
    endtask

    // One full JOY_CLK period; returns the value the poller sees at the edge.
    task automatic clk_edge(output logic sample);
        @(negedge clk12); #1;
        sample  = JOY_DATA;
        JOY_CLK = 1'b1;
        if (!reset && !m_loading) begin
            m_fd_pending = (m_cnt == W - 1);
            if (m_cnt < W) m_cnt++;
            settled = 0;
        end
        wait_cycles(4);
        @(negedge clk12); #1;
        JOY_CLK = 1'b0;
        wait_cycles(4);
    endtask

    // Load a frame and clock n edges; samples are shifted in LSB-last.
    task automatic applyStimulus(input logic [11:0] j1, input logic [11:0] j2,
                                 input int n, output logic [63:0] s);
        logic b;
        s = '0;
        set_joy(j1, j2);
        set_load(1'b0);
        set_load(1'b1);
        for (int i = 0; i < n; i++) begin
            clk_edge(b);
            s = {s[62:0], b};
        end
    endtask

    // Expected slot index of a walking zero on {joy2, joy1} bit b.
    const int exp_k [24] = '{8, 7, 6, 5, 4, 3, 2, 24, 1, 23, 21, 22,
                             16, 15, 14, 13, 12, 11, 10, 20, 9, 19, 17, 18};

    initial begin
        logic [63:0] s;
        logic [23:0] w;
        logic        b;
        int          fd0, zc, pos;

        model_reset();
        reset    = 1'b1;
        joy1     = 12'h000;
        joy2     = 12'h000;
        JOY_CLK  = 1'b0;
        JOY_LOAD = 1'b1;

        // Reset with buttons pressed and JOY_CLK toggling
        $display("[TB] reset");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk12); #1;
            JOY_CLK = ~JOY_CLK;
            wait_cycles(1);
        end
        @(negedge clk12); #1;
        JOY_CLK = 1'b0;
        wait_cycles(3);
        @(negedge clk12); #1;
        reset = 1'b0;
        model_reset();
        wait_cycles(4);
        checkOutput("post_rst_data", 32'(JOY_DATA), 32'd1);
        checkOutput("post_rst_cnt", 32'(bit_cnt), 32'd0);

        // Basic frame: only joy1[0] pressed
        $display("[TB] basic frame");
        fd0 = fd_count;
        applyStimulus(12'hFFE, 12'hFFF, 26, s);
        checkOutput("basic_stream", 32'(s[25:0]), 32'h3FDFFFF);
        checkOutput("basic_fd_count", 32'(fd_count - fd0), 32'd1);
        checkOutput("basic_cnt", 32'(bit_cnt), 32'd25);

        // Walking zero across all 24 button bits
        $display("[TB] bit-order sweep");
        for (int bi = 0; bi < 24; bi++) begin
            w = ~(24'd1 << bi);
            applyStimulus(w[11:0], w[23:12], 25, s);
            zc  = 0;
            pos = -1;
            for (int k = 0; k < 25; k++) begin
                if (s[24-k] == 1'b0) begin
                    zc++;
                    pos = k;
                end
            end
            checkOutput("sweep_zeros", 32'(zc), 32'd1);
            checkOutput("sweep_pos", 32'(pos), 32'(exp_k[bi]));
        end

        // Load and JOY_CLK edge in the same synchronised cycle
        $display("[TB] load/clock collision");
        applyStimulus(12'h0F0, 12'hA5A, 8, s);
        @(negedge clk12); #1;
        JOY_LOAD  = 1'b0;
        JOY_CLK   = 1'b1;
        m_loading = 1;
        m_cnt     = 0;
        m_fd_pending = 0;
        settled   = 0;
        wait_cycles(4);
        checkOutput("coll_cnt_low", 32'(bit_cnt), 32'd0);
        set_load(1'b1);
        @(negedge clk12); #1;
        JOY_CLK = 1'b0;
        wait_cycles(4);
        checkOutput("coll_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("coll_data", 32'(JOY_DATA), 32'd1);
        clk_edge(b);
        checkOutput("coll_slot1", 32'(JOY_DATA), 32'd0);

        // Mid-frame reload aborts the frame
        $display("[TB] mid-frame reload");
        fd0 = fd_count;
        applyStimulus(12'h123, 12'h456, 10, s);
        set_joy(12'hABC, 12'h321);
        set_load(1'b0);
        set_load(1'b1);
        checkOutput("reload_fd_none", 32'(fd_count - fd0), 32'd0);
        checkOutput("reload_cnt", 32'(bit_cnt), 32'd0);
        checkOutput("reload_lead", 32'(JOY_DATA), 32'd1);
        clk_edge(b);
        checkOutput("reload_slot1", 32'(JOY_DATA), 32'd0);
        for (int i = 0; i < 24; i++) clk_edge(b);
        checkOutput("reload_fd_once", 32'(fd_count - fd0), 32'd1);

        // Reset in the middle of a frame
        $display("[TB] mid-frame reset");
        applyStimulus(12'hFF7, 12'hFFF, 5, s);
        checkOutput("pre_rst_data", 32'(JOY_DATA), 32'd0);
        @(negedge clk12); #1;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_data", 32'(JOY_DATA), 32'd1);
        checkOutput("async_rst_cnt", 32'(bit_cnt), 32'd0);
        wait_cycles(3);
        @(negedge clk12); #1;
        reset = 1'b0;
        model_reset();
        wait_cycles(4);

        // Saturation, with inputs changing during shifting
        $display("[TB] saturation");
        fd0 = fd_count;
        applyStimulus(12'hF0F, 12'h0FF, 12, s);
        set_joy(12'h000, 12'h000);
        for (int i = 0; i < 14; i++) clk_edge(b);
        set_joy(12'h5A5, 12'hA5A);
        for (int i = 0; i < 14; i++) clk_edge(b);
        checkOutput("sat_cnt", 32'(bit_cnt), 32'd25);
        checkOutput("sat_fd_once", 32'(fd_count - fd0), 32'd1);
        checkOutput("sat_data", 32'(JOY_DATA), 32'd1);

        wait_cycles(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
